// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter that sequences one request at a time through an external logic unit.
// Accept-to-rsp_valid latency is EXEC_CYCLES+1; new requests are held off (req_ready=0) until the response is taken.
module logic_op_arbiter #(
    parameter int   NUM_REQ     = 2,
    parameter int   WIDTH       = 4,
    parameter int   EXEC_CYCLES = 1,
    localparam int  IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [1:0]               lu_op,
    output logic [WIDTH-1:0]         lu_a,
    output logic [WIDTH-1:0]         lu_b,
    input  logic [WIDTH-1:0]         lu_out,
    output logic                     busy,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [IDW-1:0]           rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [3:0]         r_cnt;
    logic [1:0]         r_lu_op;
    logic [WIDTH-1:0]   r_lu_a;
    logic [WIDTH-1:0]   r_lu_b;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [IDW-1:0]     r_rsp_id;

    logic               w_found;
    logic [IDW-1:0]     w_gnt;
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_op    = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_gnt   = IDW'(idx);
                w_op    = req_op[2*idx +: 2];
                w_a     = req_a[WIDTH*idx +: WIDTH];
                w_b     = req_b[WIDTH*idx +: WIDTH];
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_found;

    always_comb begin
        w_ready = '0;
        if (w_accept && rst_n) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_lu_op    <= '0;
            r_lu_a     <= '0;
            r_lu_b     <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lu_op  <= w_op;
                        r_lu_a   <= w_a;
                        // NOT only uses operand a; keep b quiet on the unit.
                        r_lu_b   <= (w_op == 2'b11) ? '0 : w_b;
                        r_rsp_id <= w_gnt;
                        r_ptr    <= (w_gnt == IDW'(NUM_REQ-1)) ? '0 : w_gnt + 1'b1;
                        r_cnt    <= 4'(EXEC_CYCLES-1);
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_data <= lu_out;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign lu_op     = r_lu_op;
    assign lu_a      = r_lu_a;
    assign lu_b      = r_lu_b;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: EXEC_CYCLES=1 instance with a combinational unit, EXEC_CYCLES=4 instance with a 3-cycle unit.
module tb_logic_op_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [3:0] lu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~a;
        endcase
    endfunction

    // EXEC_CYCLES = 1 instance
    logic [1:0] req_valid = '0, req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic [1:0] lu_op;
    logic [3:0] lu_a, lu_b, lu_out, rsp_data;
    logic       busy, rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [0:0] rsp_id;

    assign lu_out = lu_f(lu_op, lu_a, lu_b);

    logic_op_arbiter #(.NUM_REQ(2), .WIDTH(4), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_out(lu_out),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    // EXEC_CYCLES = 4 instance; unit result lags its inputs by 3 cycles
    logic [1:0] req_valid4 = '0, req_ready4;
    logic [3:0] req_op4 = '0;
    logic [7:0] req_a4 = '0, req_b4 = '0;
    logic [1:0] lu_op4;
    logic [3:0] lu_a4, lu_b4, lu_out4, rsp_data4;
    logic       busy4, rsp_valid4;
    logic       rsp_ready4 = 1'b1;
    logic [0:0] rsp_id4;
    logic [3:0] d1 = '0, d2 = '0, d3 = '0;

    always @(posedge clk) begin
        d1 <= lu_f(lu_op4, lu_a4, lu_b4);
        d2 <= d1;
        d3 <= d2;
    end
    assign lu_out4 = d3;

    logic_op_arbiter #(.NUM_REQ(2), .WIDTH(4), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op(req_op4), .req_a(req_a4), .req_b(req_b4),
        .lu_op(lu_op4), .lu_a(lu_a4), .lu_b(lu_b4), .lu_out(lu_out4),
        .busy(busy4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_data(rsp_data4), .rsp_id(rsp_id4)
    );

    // Scoreboard for the EXEC_CYCLES=1 instance
    typedef struct packed {
        logic [0:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   mptr  = 0;
    int   n_rsp = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mptr = 0;
        end else begin
            if (req_ready != 2'b00) begin
                int g;
                g = -1;
                for (int k = 0; k < 2; k++) begin
                    int i;
                    i = (mptr + k) % 2;
                    if (g < 0 && req_valid[i]) g = i;
                end
                n_checks++;
                if (g < 0 || req_ready !== 2'(1 << g))
                    $display("FAIL grant: req_ready=%b req_valid=%b model_ptr=%0d", req_ready, req_valid, mptr);
                else
                    n_pass++;
                if (g >= 0) begin
                    sb.push_back(exp_t'({1'(g), lu_f(req_op[2*g +: 2], req_a[4*g +: 4], req_b[4*g +: 4])}));
                    mptr = (g + 1) % 2;
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: id=%0d data=%b with empty scoreboard", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== e)
                        $display("FAIL rsp_data: got id=%0d data=%b exp id=%0d data=%b", rsp_id, rsp_data, e.id, e.data);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready} !== 19'd0)
            $display("FAIL reset_dut1: outputs=%h exp 0", {lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready});
        else n_pass++;
        n_checks++;
        if ({lu_op4, lu_a4, lu_b4, rsp_data4, rsp_id4, rsp_valid4, busy4, req_ready4} !== 19'd0)
            $display("FAIL reset_dut4: outputs=%h exp 0", {lu_op4, lu_a4, lu_b4, rsp_data4, rsp_id4, rsp_valid4, busy4, req_ready4});
        else n_pass++;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp_valid, req_ready} !== 4'b0000)
            $display("FAIL reset_release: busy/rsp_valid/req_ready=%b exp 0000", {busy, rsp_valid, req_ready});
        else n_pass++;
    endtask

    task automatic test_single;
        tick;
        req_op[1:0] = 2'b00; req_a[3:0] = 4'b0101; req_b[3:0] = 4'b1010; req_valid = 2'b01;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy, rsp_valid, lu_op, lu_a, lu_b} !== {2'b00, 1'b1, 1'b0, 2'b00, 4'b0101, 4'b1010})
            $display("FAIL single_exec: ready=%b busy=%b rsp_valid=%b lu=%b/%b/%b", req_ready, busy, rsp_valid, lu_op, lu_a, lu_b);
        else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'b1111, 1'b0})
            $display("FAIL single_rsp: valid=%b data=%b id=%0d exp 1/1111/0", rsp_valid, rsp_data, rsp_id);
        else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done: rsp_valid/busy=%b exp 00", {rsp_valid, busy}); else n_pass++;
        tick;
    endtask

    task automatic test_alternate;
        int grants[$];
        int exp_g[4];
        int r0;
        exp_g = '{0, 1, 0, 1};
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        r0 = n_rsp;
        req_op = 4'b1001; req_a = 8'b1100_1100; req_b = 8'b1010_1010; req_valid = 2'b11;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) grants.push_back(req_ready == 2'b10 ? 1 : 0);
            tick;
        end
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= grants.size() || grants[i] !== exp_g[i])
                $display("FAIL alt_grant%0d: got %0d exp %0d (grants seen %0d)", i, (i < grants.size()) ? grants[i] : -1, exp_g[i], grants.size());
            else n_pass++;
        end
        for (int c = 0; c < 30 && sb.size() != 0; c++) tick;
        n_checks++;
        if (n_rsp - r0 !== 4 || sb.size() != 0)
            $display("FAIL alt_count: responses=%0d pending=%0d exp 4/0", n_rsp - r0, sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int c;
        req_op[3:2] = 2'b00; req_a[7:4] = 4'b0110; req_b[7:4] = 4'b0011; req_valid = 2'b10; rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL bp_ready: got %b exp 10", req_ready); else n_pass++;
        tick;
        req_op[1:0] = 2'b11; req_a[3:0] = 4'b0000; req_b[3:0] = 4'b0101; req_valid = 2'b01;
        c = 0;
        @(negedge clk);
        while (!rsp_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== {1'b1, 4'b0101, 1'b1, 1'b1, 2'b00})
                $display("FAIL bp_hold%0d: valid=%b data=%b id=%0d busy=%b ready=%b exp 1/0101/1/1/00", i, rsp_valid, rsp_data, rsp_id, busy, req_ready);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready} !== 3'b100) $display("FAIL bp_handshake: rsp_valid/req_ready=%b exp 100", {rsp_valid, req_ready}); else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL bp_next: got %b exp 01", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        for (int k = 0; k < 30 && sb.size() != 0; k++) tick;
    endtask

    task automatic test_not;
        req_op[3:2] = 2'b11; req_a[7:4] = 4'b0011; req_b[7:4] = 4'b1111; req_valid = 2'b10;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL not_ready: got %b exp 10", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({lu_op, lu_a, lu_b} !== {2'b11, 4'b0011, 4'b0000})
            $display("FAIL not_lu: got %b/%b/%b exp 11/0011/0000", lu_op, lu_a, lu_b);
        else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'b1100, 1'b1})
            $display("FAIL not_rsp: valid=%b data=%b id=%0d exp 1/1100/1", rsp_valid, rsp_data, rsp_id);
        else n_pass++;
        tick;
    endtask

    task automatic test_exec4;
        req_op4[1:0] = 2'b01; req_a4[3:0] = 4'b1101; req_b4[3:0] = 4'b0111; req_valid4 = 2'b01;
        @(negedge clk);
        n_checks++;
        if (req_ready4 !== 2'b01) $display("FAIL ex4_ready: got %b exp 01", req_ready4); else n_pass++;
        tick;
        req_valid4 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid4, busy4, lu_op4, lu_a4, lu_b4} !== {1'b0, 1'b1, 2'b01, 4'b1101, 4'b0111})
                $display("FAIL ex4_hold%0d: rsp_valid=%b busy=%b lu=%b/%b/%b", i, rsp_valid4, busy4, lu_op4, lu_a4, lu_b4);
            else n_pass++;
            tick;
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid4, rsp_data4, rsp_id4} !== {1'b1, 4'b0101, 1'b0})
            $display("FAIL ex4_rsp: valid=%b data=%b id=%0d exp 1/0101/0", rsp_valid4, rsp_data4, rsp_id4);
        else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if (rsp_valid4 !== 1'b0) $display("FAIL ex4_done: rsp_valid=%b exp 0", rsp_valid4); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid;
        int c;
        // Reset while in EXEC
        req_op = 4'b0101; req_a = 8'hFF; req_b = 8'hFF; req_valid = 2'b01; rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL rstx_ready: got %b exp 01", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready} !== 19'd0)
            $display("FAIL rstx_zero: outputs=%h exp 0", {lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL rstx_norsp%0d: rsp_valid=%b exp 0", i, rsp_valid); else n_pass++;
        end
        tick;
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL rstx_ptr: got %b exp 01", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        // Reset while in RESP
        c = 0;
        @(negedge clk);
        while (!rsp_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL rstr_wait: rsp_valid=%b exp 1", rsp_valid); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready} !== 19'd0)
            $display("FAIL rstr_zero: outputs=%h exp 0", {lu_op, lu_a, lu_b, rsp_data, rsp_id, rsp_valid, busy, req_ready});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL rstr_norsp%0d: rsp_valid=%b exp 0", i, rsp_valid); else n_pass++;
        end
        tick;
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL rstr_ptr: got %b exp 01", req_ready); else n_pass++;
        tick;
        req_valid = 2'b00;
        for (int k = 0; k < 30 && sb.size() != 0; k++) tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_alternate;
        test_backpressure;
        test_not;
        test_exec4;
        test_reset_mid;
        repeat (3) tick;
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d responses never arrived", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
